// File: rtl/iir_coeff_ctrl_pkg.sv
// Shared definitions for the IIR coefficient controller: FSM encoding,
// coefficient address map and the unity-gain coefficient helper.
package iir_coeff_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_FLUSH   = 2'd2,
        ST_ACK     = 2'd3
    } state_t;

    // b[0..N] live at B_BASE, a[0..N-1] follow immediately after the b bank
    localparam int B_BASE = 0;

    function automatic int a_base(input int n);
        return n + 1;
    endfunction

    function automatic longint unsigned unity_coeff(input int q);
        return 64'd1 << q;
    endfunction

endpackage

// File: rtl/iir_coeff_bank.sv
// Coefficient register bank: single-entry write port, whole-bank parallel
// load, and a packed view of every entry. Entry 0 resets to RESET_VAL0.
module iir_coeff_bank #(
    parameter int NUM         = 5,
    parameter int COEFF_WIDTH = 16,
    parameter int IDX_WIDTH   = 4,
    parameter logic [COEFF_WIDTH-1:0] RESET_VAL0 = '0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [IDX_WIDTH-1:0]       wr_idx,
    input  logic [COEFF_WIDTH-1:0]     wr_data,
    input  logic                       load_en,
    input  logic [NUM*COEFF_WIDTH-1:0] load_data,
    output logic [NUM*COEFF_WIDTH-1:0] coeffs
);

    logic [COEFF_WIDTH-1:0] regs [NUM];

    // Parallel load wins over a single write so the bank switches as a unit
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM; i++) begin
            if (!rst_n) begin
                regs[i] <= (i == 0) ? RESET_VAL0 : '0;
            end else if (load_en) begin
                regs[i] <= load_data[i*COEFF_WIDTH +: COEFF_WIDTH];
            end else if (wr_en && (wr_idx == IDX_WIDTH'(i))) begin
                regs[i] <= wr_data;
            end
        end
    end

    for (genvar g = 0; g < NUM; g++) begin : g_pack
        assign coeffs[g*COEFF_WIDTH +: COEFF_WIDTH] = regs[g];
    end

endmodule

// File: rtl/iir_coeff_ctrl.sv
// Coefficient controller for a direct-form I IIR filter: shadow writes,
// atomic commit on a sample boundary, then a timed flush of the filter state.
//
// state   | meaning
// IDLE    | accepting host writes; commit_req starts a commit
// PENDING | waiting for sample_en to swap shadow into active
// FLUSH   | filter held in reset while flush counter runs down
// ACK     | flush done; commit_ack issued on the way back to IDLE
module iir_coeff_ctrl
    import iir_coeff_ctrl_pkg::*;
#(
    parameter int N            = 2,
    parameter int COEFF_WIDTH  = 16,
    parameter int Q            = 14,
    parameter int ADDR_WIDTH   = 4,
    parameter int FLUSH_CYCLES = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         sample_en,
    input  logic                         wr_valid,
    output logic                         wr_ready,
    input  logic [ADDR_WIDTH-1:0]        wr_addr,
    input  logic [COEFF_WIDTH-1:0]       wr_data,
    input  logic                         commit_req,
    output logic                         commit_ack,
    output logic                         busy,
    output logic                         addr_err,
    input  logic                         err_clr,
    output logic [COEFF_WIDTH*(N+1)-1:0] packed_b_coeffs,
    output logic [COEFF_WIDTH*N-1:0]     packed_a_coeffs,
    output logic                         filter_rst_n
);

    localparam int NUM    = 2*N + 1;
    localparam int A_BASE = a_base(N);
    localparam int CNT_W  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [COEFF_WIDTH-1:0] UNITY    = COEFF_WIDTH'(unity_coeff(Q));
    localparam logic [ADDR_WIDTH-1:0]  MAX_ADDR = ADDR_WIDTH'(2*N);
    localparam logic [CNT_W-1:0]       CNT_INIT = CNT_W'(FLUSH_CYCLES - 1);

    state_t                     state, state_next;
    logic [CNT_W-1:0]           cnt, cnt_next;
    logic                       accept, addr_bad, shadow_wr, load_active;
    logic [NUM*COEFF_WIDTH-1:0] shadow_coeffs, active_coeffs;

    assign accept    = wr_valid && wr_ready;
    assign addr_bad  = wr_addr > MAX_ADDR;
    assign shadow_wr = accept && !addr_bad;

    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        load_active = 1'b0;
        case (state)
            ST_IDLE: begin
                if (commit_req) state_next = ST_PENDING;
            end
            ST_PENDING: begin
                if (sample_en) begin
                    load_active = 1'b1;
                    cnt_next    = CNT_INIT;
                    state_next  = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (cnt == '0) state_next = ST_ACK;
                else           cnt_next   = cnt - 1'b1;
            end
            ST_ACK:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they align with it
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            wr_ready     <= 1'b0;
            busy         <= 1'b0;
            commit_ack   <= 1'b0;
            filter_rst_n <= 1'b0;
            addr_err     <= 1'b0;
        end else begin
            state        <= state_next;
            cnt          <= cnt_next;
            wr_ready     <= (state_next == ST_IDLE);
            busy         <= (state_next inside {ST_PENDING, ST_FLUSH});
            commit_ack   <= (state == ST_ACK);
            filter_rst_n <= (state_next != ST_FLUSH);
            if (err_clr)                  addr_err <= 1'b0;
            else if (accept && addr_bad)  addr_err <= 1'b1;
        end
    end

    iir_coeff_bank #(
        .NUM         (NUM),
        .COEFF_WIDTH (COEFF_WIDTH),
        .IDX_WIDTH   (ADDR_WIDTH),
        .RESET_VAL0  (UNITY)
    ) u_shadow (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (shadow_wr),
        .wr_idx    (wr_addr),
        .wr_data   (wr_data),
        .load_en   (1'b0),
        .load_data ('0),
        .coeffs    (shadow_coeffs)
    );

    iir_coeff_bank #(
        .NUM         (NUM),
        .COEFF_WIDTH (COEFF_WIDTH),
        .IDX_WIDTH   (ADDR_WIDTH),
        .RESET_VAL0  (UNITY)
    ) u_active (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (1'b0),
        .wr_idx    ('0),
        .wr_data   ('0),
        .load_en   (load_active),
        .load_data (shadow_coeffs),
        .coeffs    (active_coeffs)
    );

    assign packed_b_coeffs = active_coeffs[COEFF_WIDTH*B_BASE +: COEFF_WIDTH*(N+1)];
    assign packed_a_coeffs = active_coeffs[COEFF_WIDTH*A_BASE +: COEFF_WIDTH*N];

endmodule
